multdiv_iter: RTL and testbench

MULTDIV_ITER -- requirements
Module: multdiv_iter

---
 rtl/multdiv_pkg.sv | 6 +
 rtl/multdiv_iter_addsub_w.sv | 14 +
 rtl/multdiv_iter.sv | 113 +++++++++++
 tb/tb_multdiv_iter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// multdiv_pkg: state and operation encodings shared by the iterative multiply/divide unit
package multdiv_pkg;
   typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;
   localparam logic OP_MUL = 1'b0;
   localparam logic OP_DIV = 1'b1;
endpackage

// File: rtl/multdiv_iter_addsub_w.sv
// addsub_w: W-bit adder/subtractor with carry out (carry set on subtract means no borrow)
module addsub_w #(
   parameter int W = 33
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   input  logic         i_sub,
   output logic [W-1:0] o_sum,
   output logic         o_cout
);
   logic [W:0] w_full;
   assign w_full = {1'b0, i_a} + {1'b0, i_sub ? ~i_b : i_b} + {{W{1'b0}}, i_sub};
   assign {o_cout, o_sum} = w_full;
endmodule

// File: rtl/multdiv_iter.sv
// multdiv_iter: radix-2 iterative multiplier / restoring divider on operand magnitudes,
// with a final sign-fix cycle and a valid/ready handshake on both sides.
module multdiv_iter
   import multdiv_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter bit SIGNED = 1'b1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic [WIDTH-1:0] out_rem,
   output logic             out_exception
);
   localparam int CW = $clog2(WIDTH + 1);
   state_t           r_state, w_next;
   logic             r_op, r_neg_q, r_neg_r, r_exc;
   logic [WIDTH-1:0] r_hi, r_lo, r_m, r_res, r_rem;
   logic [CW-1:0]    r_cnt;
   logic             w_acc, w_dz, w_sa, w_sb, w_sub, w_cout, w_mul_ovf;
   logic [WIDTH-1:0] w_a_mag, w_b_mag, w_fix_res, w_fix_rem;
   logic [WIDTH:0]   w_add_a, w_add_b, w_sum;
   logic             w_fix_exc;

   assign w_sa     = SIGNED && in_a[WIDTH-1];
   assign w_sb     = SIGNED && in_b[WIDTH-1];
   assign w_a_mag  = w_sa ? -in_a : in_a;
   assign w_b_mag  = w_sb ? -in_b : in_b;
   assign in_ready = !reset && !flush && (r_state == IDLE || (r_state == DONE && out_ready));
   assign w_acc    = in_valid && in_ready;
   assign w_dz     = in_op == OP_DIV && in_b == '0;

   // Divide shifts the next dividend bit into the partial remainder; multiply adds the
   // multiplicand only when the current multiplier bit is set.
   assign w_sub   = r_op == OP_DIV;
   assign w_add_a = w_sub ? {r_hi, r_lo[WIDTH-1]} : {1'b0, r_hi};
   assign w_add_b = (w_sub || r_lo[0]) ? {1'b0, r_m} : '0;

   addsub_w #(.W(WIDTH + 1)) u_addsub (
      .i_a   (w_add_a),
      .i_b   (w_add_b),
      .i_sub (w_sub),
      .o_sum (w_sum),
      .o_cout(w_cout)
   );

   // A negative product fits when its magnitude is at most 2^(WIDTH-1).
   assign w_mul_ovf = r_hi != '0 || (SIGNED && r_lo[WIDTH-1] && (!r_neg_q || r_lo[WIDTH-2:0] != '0));
   assign w_fix_res = r_neg_q ? -r_lo : r_lo;
   assign w_fix_rem = w_sub ? (r_neg_r ? -r_hi : r_hi) : '0;
   assign w_fix_exc = w_sub ? (SIGNED && !r_neg_q && r_lo[WIDTH-1]) : w_mul_ovf;

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = w_acc ? (w_dz ? DONE : BUSY) : IDLE;
         BUSY:    w_next = r_cnt == CW'(WIDTH - 1) ? FIX : BUSY;
         FIX:     w_next = DONE;
         DONE:    w_next = w_acc ? (w_dz ? DONE : BUSY) : (out_ready ? IDLE : DONE);
         default: w_next = IDLE;
      endcase
      if (flush) w_next = IDLE;
   end

   always_ff @(posedge clock) r_state <= reset ? IDLE : w_next;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_op    <= 1'b0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_m     <= '0;
         r_cnt   <= '0;
         r_res   <= '0;
         r_rem   <= '0;
         r_exc   <= 1'b0;
      end else if (w_acc) begin
         r_op    <= in_op;
         r_neg_q <= w_sa ^ w_sb;
         r_neg_r <= w_sa;
         r_hi    <= '0;
         r_lo    <= in_op == OP_DIV ? w_a_mag : w_b_mag;
         r_m     <= in_op == OP_DIV ? w_b_mag : w_a_mag;
         r_cnt   <= '0;
         r_res   <= '0;
         r_rem   <= '0;
         r_exc   <= w_dz;
      end else if (r_state == BUSY) begin
         r_cnt <= r_cnt + 1'b1;
         r_hi  <= w_sub ? (w_cout ? w_sum[WIDTH-1:0] : w_add_a[WIDTH-1:0]) : w_sum[WIDTH:1];
         r_lo  <= w_sub ? {r_lo[WIDTH-2:0], w_cout} : {w_sum[0], r_lo[WIDTH-1:1]};
      end else if (r_state == FIX) begin
         r_res <= w_fix_res;
         r_rem <= w_fix_rem;
         r_exc <= w_fix_exc;
      end
   end

   assign out_valid     = r_state == DONE && !reset;
   assign out_result    = out_valid ? r_res : '0;
   assign out_rem       = out_valid ? r_rem : '0;
   assign out_exception = out_valid && r_exc;
endmodule

// File: tb/tb_multdiv_iter.sv
// tb_multdiv_iter: directed and random checks of multdiv_iter (32-bit signed, 8-bit unsigned)
// against an arithmetic reference model.
module tb_multdiv_iter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        v, rdy, op, fl, ov, ordy, exc;
   logic [31:0] a, b, res, rem;
   logic        v8, rdy8, op8, fl8, ov8, ordy8, exc8;
   logic [7:0]  a8, b8, res8, rem8;
   int          checks = 0;
   int          fails = 0;

   multdiv_iter #(.WIDTH(32), .SIGNED(1'b1)) u_dut32 (
      .clock(clk), .reset(rst), .in_valid(v), .in_ready(rdy), .in_op(op), .in_a(a), .in_b(b),
      .flush(fl), .out_valid(ov), .out_ready(ordy), .out_result(res), .out_rem(rem),
      .out_exception(exc)
   );

   multdiv_iter #(.WIDTH(8), .SIGNED(1'b0)) u_dut8 (
      .clock(clk), .reset(rst), .in_valid(v8), .in_ready(rdy8), .in_op(op8), .in_a(a8), .in_b(b8),
      .flush(fl8), .out_valid(ov8), .out_ready(ordy8), .out_result(res8), .out_rem(rem8),
      .out_exception(exc8)
   );

   task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Signed 32-bit reference: plain 64-bit arithmetic, SV division truncates toward zero.
   function automatic void m32(input logic o, input logic [31:0] x, input logic [31:0] y,
                               output logic [31:0] r, output logic [31:0] m, output logic e,
                               output int l);
      longint p;
      p = longint'($signed(x)) * longint'($signed(y));
      r = p[31:0];
      m = '0;
      e = 1'b0;
      l = 34;
      if (o) begin
         if (y == '0) begin
            r = '0;
            e = 1'b1;
            l = 1;
         end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            r = x;
            e = 1'b1;
         end else begin
            r = $signed(x) / $signed(y);
            m = $signed(x) % $signed(y);
         end
      end else e = p != longint'($signed(r));
   endfunction

   function automatic void m8(input logic o, input logic [7:0] x, input logic [7:0] y,
                              output logic [7:0] r, output logic [7:0] m, output logic e,
                              output int l);
      int p;
      p = int'(x) * int'(y);
      r = p[7:0];
      m = '0;
      e = p > 255;
      l = 10;
      if (o) begin
         e = y == '0;
         r = e ? 8'd0 : x / y;
         m = e ? 8'd0 : x % y;
         l = e ? 1 : 10;
      end
   endfunction

   task automatic start32(input logic o, input logic [31:0] x, input logic [31:0] y);
      int n = 0;
      v = 1'b1;
      op = o;
      a = x;
      b = y;
      #1;
      while (!rdy && n < 100) begin
         tick();
         n++;
      end
      check("in_ready", rdy, 1);
      tick();
      v = 1'b0;
      op = 1'($urandom);
      a = $urandom;
      b = $urandom;
   endtask

   task automatic finish32(input logic o, input logic [31:0] x, input logic [31:0] y, input int hold);
      logic [31:0] er, em;
      logic        ee;
      int          el;
      int          lat = 1;
      m32(o, x, y, er, em, ee, el);
      ordy = hold == 0;
      #1;
      while (!ov && lat < 100) begin
         tick();
         lat++;
      end
      check("latency", lat, el);
      check("result", res, er);
      check("rem", rem, em);
      check("exception", exc, ee);
      for (int i = 0; i < hold; i++) begin
         tick();
         check("hold_stable", {ov, exc, res, rem}, {1'b1, ee, er, em});
      end
      ordy = 1'b1;
   endtask

   task automatic consume32();
      tick();
      check("idle_zero", {ov, exc, res, rem}, '0);
   endtask

   task automatic run32(input logic o, input logic [31:0] x, input logic [31:0] y, input int hold);
      start32(o, x, y);
      finish32(o, x, y, hold);
      consume32();
   endtask

   task automatic run8(input logic o, input logic [7:0] x, input logic [7:0] y);
      logic [7:0] er, em;
      logic       ee;
      int         el;
      int         lat = 1;
      int         n = 0;
      m8(o, x, y, er, em, ee, el);
      v8 = 1'b1;
      op8 = o;
      a8 = x;
      b8 = y;
      #1;
      while (!rdy8 && n < 100) begin
         tick();
         n++;
      end
      check("in_ready8", rdy8, 1);
      tick();
      v8 = 1'b0;
      op8 = 1'($urandom);
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      while (!ov8 && lat < 100) begin
         tick();
         lat++;
      end
      check("latency8", lat, el);
      check("result8", {exc8, res8, rem8}, {ee, er, em});
      tick();
      check("idle_zero8", {ov8, exc8, res8, rem8}, '0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: run did not complete");
      $fatal(1);
   end

   initial begin
      int          n;
      logic        ro;
      logic [31:0] ra, rb;
      v = 0; op = 0; a = 0; b = 0; fl = 0; ordy = 1;
      v8 = 0; op8 = 0; a8 = 0; b8 = 0; fl8 = 0; ordy8 = 1;
      rst = 1'b1;
      repeat (3) tick();
      check("rst_ready", {rdy, rdy8}, 0);
      check("rst_valid", {ov, ov8}, 0);
      rst = 1'b0;
      #1;
      check("post_rst_ready", {rdy, rdy8}, 2'b11);

      run32(0, 32'd7, 32'hFFFF_FFFA, 0);
      run32(1, 32'hFFFF_FFF9, 32'd2, 0);
      run32(1, 32'd5, 32'd0, 0);
      run32(0, 32'h0001_0000, 32'h0001_0000, 0);
      run32(1, 32'h8000_0000, 32'hFFFF_FFFF, 0);

      start32(0, 32'h1234, 32'h5678);
      repeat (9) tick();
      fl = 1'b1;
      #1;
      check("flush_blocks_ready", rdy, 0);
      tick();
      fl = 1'b0;
      #1;
      check("flush_idle", {rdy, ov}, 2'b10);
      n = 0;
      repeat (40) begin
         tick();
         n += int'(ov);
      end
      check("flush_no_output", n, 0);
      run32(0, 32'd3, 32'd4, 0);

      start32(0, 32'd7, 32'hFFFF_FFFA);
      finish32(0, 32'd7, 32'hFFFF_FFFA, 5);
      start32(1, 32'd100, 32'd7);
      check("chain_not_valid", ov, 0);
      finish32(1, 32'd100, 32'd7, 0);
      consume32();

      start32(1, 32'd1000, 32'd3);
      repeat (4) tick();
      rst = 1'b1;
      #1;
      check("rst_mid_ready", rdy, 0);
      check("rst_mid_valid", ov, 0);
      tick();
      rst = 1'b0;
      #1;
      check("rst_mid_idle", rdy, 1);
      n = 0;
      repeat (40) begin
         tick();
         n += int'(ov);
      end
      check("rst_mid_no_output", n, 0);

      repeat (40) begin
         ro = 1'($urandom);
         ra = $urandom;
         rb = $urandom;
         if ($urandom_range(0, 1) == 1) ra = $signed(ra) >>> $urandom_range(8, 31);
         if ($urandom_range(0, 1) == 1) rb = $signed(rb) >>> $urandom_range(8, 31);
         if ($urandom_range(0, 9) == 0) rb = '0;
         if ($urandom_range(0, 15) == 0) begin
            ra = 32'h8000_0000;
            rb = 32'hFFFF_FFFF;
         end
         run32(ro, ra, rb, int'($urandom_range(0, 2)));
      end

      run8(1, 8'd200, 8'd7);
      run8(0, 8'd15, 8'd17);
      run8(0, 8'd16, 8'd16);
      run8(1, 8'd9, 8'd0);
      repeat (30) run8(1'($urandom), 8'($urandom), 8'($urandom_range(0, 255)));

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
